am_constants_loader: RTL and testbench
======================================

AM_CONSTANTS_LOADER -- requirements
Module: am_constants_loader

Interface
- REQ-001 The block SHALL have the parameter NUM_CONST, default 8, giving the number of 16-bit AM constants held (power of two, at most 8).
- REQ-002 The block SHALL have the port Clock, input, 1 bit, the single rising-edge clock.
- REQ-003 The block SHALL have the port Reset_n, input, 1 bit, the asynchronous active-low reset.
- REQ-004 The block SHALL have the port Frame_Start, input, 1 bit, a one-cycle pulse that opens a serial frame.
- REQ-005 The block SHALL have the port Ser_En, input, 1 bit, a qualifier for one serial bit on Ser_Din in this cycle.
- REQ-006 The block SHALL have the port Ser_Din, input, 1 bit, the serial data, MSB first.
- REQ-007 The block SHALL have the port Commit, input, 1 bit, a pulse that requests a shadow-to-active bank copy.
- REQ-008 The block SHALL have the port Sel, input, 3 bits, the index of the active constant driven on Dout.
- REQ-009 The block SHALL have the port Dout, output, 16 bits, the registered active constant feeding the AM value path.
- REQ-010 The block SHALL have the port Word_Done, output, 1 bit, a one-cycle pulse marking a shadow write.
- REQ-011 The block SHALL have the port Commit_Ack, output, 1 bit, a one-cycle pulse marking an active-bank update.
- REQ-012 The block SHALL have the port Frame_Err, output, 1 bit, a one-cycle pulse marking an aborted or rejected frame.

Function
- REQ-013 A frame SHALL be 20 bits: addr[3:0] followed by data[15:0]; only bits taken with Ser_En=1 count.
- REQ-014 The FSM SHALL have the states IDLE, SHIFT and WRITE: IDLE goes to SHIFT on Frame_Start; SHIFT goes to WRITE after the last counted bit; WRITE goes to IDLE after one cycle.
- REQ-015 In IDLE, Ser_En SHALL be ignored.
- REQ-016 In WRITE, the block SHALL store data into shadow[addr[2:0]] and pulse Word_Done exactly once.
- REQ-017 When addr[3]=1 or addr[2:0] >= NUM_CONST, the block SHALL discard the data, pulse Frame_Err, and leave Word_Done low.
- REQ-018 A Frame_Start in SHIFT or WRITE SHALL abort the current frame, pulse Frame_Err, and restart SHIFT with the bit counter at 0.
- REQ-019 The bit counter SHALL be 5 bits wide and SHALL never wrap within a frame.
- REQ-020 Commit SHALL copy every shadow entry to the active bank on the next edge, and Commit_Ack SHALL pulse in the cycle the new values are visible.
- REQ-021 A Commit coinciding with WRITE SHALL be deferred one cycle so that the copy includes the word just written; Commit_Ack is then delayed by one cycle.
- REQ-022 Dout SHALL equal active[Sel] registered, with a latency of 1 cycle from Sel or active-bank change.
- REQ-023 When Sel >= NUM_CONST, Dout SHALL be 0.
- REQ-024 The active bank SHALL change only through Commit, so constants seen by the value path are updated atomically.

Reset
- REQ-025 While Reset_n=0, the FSM SHALL be IDLE, the bit counter 0, the shadow and active banks 0, Dout 0, the pending commit cleared, and Word_Done, Commit_Ack and Frame_Err 0.
- REQ-026 A reset asserted mid-frame SHALL discard the partial frame, and no Frame_Err SHALL be raised for it.
- REQ-027 Reset release SHALL be synchronised internally so that leaving reset is glitch-free.

Configuration
- REQ-028 With AM_LOADER_PARITY_EN defined, a frame SHALL be 21 bits, the last bit being even parity over the preceding 20 bits.
- REQ-029 With AM_LOADER_PARITY_EN defined, a parity mismatch SHALL discard the word and pulse Frame_Err in place of Word_Done.
- REQ-030 With AM_LOADER_PARITY_EN undefined, frames SHALL be 20 bits and no parity logic SHALL exist.

Structure
- REQ-031 A shared package am_const_pkg SHALL hold the FSM state enum, the AM_CONST_W=16 and FRAME_ADDR_W=4 constants, and the frame length constants.
- REQ-032 The block SHALL have one sub-module, am_const_bank, which holds the shadow and active arrays, the commit copy, and the Dout read register.

Verification
- REQ-033 The bench SHALL check: after reset, a frame with addr=2 and data=0x1234, then Commit -> Word_Done 1 pulse, Commit_Ack 1 pulse, and with Sel=2 Dout=0x1234 one cycle later.
- REQ-034 The bench SHALL check: write 0xAAAA to addr 1 with no Commit, Sel=1 -> Dout stays 0; after Commit -> Dout=0xAAAA.
- REQ-035 The bench SHALL check: Frame_Start after 9 bits, then a full frame with addr 3 and data 0x0F0F -> Frame_Err 1 pulse, only 0x0F0F stored.
- REQ-036 The bench SHALL check: Commit in the same cycle as WRITE of addr 0 with data 0xBEEF -> Commit_Ack one cycle later, and Dout(Sel=0)=0xBEEF.
- REQ-037 The bench SHALL check: a frame with addr=0x9 -> Frame_Err, no Word_Done, and all banks unchanged.
- REQ-038 The bench SHALL check, with AM_LOADER_PARITY_EN defined: data 0x0001 to addr 0 with the parity bit flipped -> Frame_Err, shadow[0] stays 0.

Source files
------------

// File: rtl/am_const_pkg.sv
// Shared types and constants for the AM constants loader.
// Latency: n/a (package only).
// Backpressure: n/a; frame length grows by one parity bit when AM_LOADER_PARITY_EN is defined.
package am_const_pkg;

    localparam int AM_CONST_W     = 16;
    localparam int FRAME_ADDR_W   = 4;
    // Address plus data bits, i.e. the payload that carries the constant.
    localparam int FRAME_DATA_LEN = FRAME_ADDR_W + AM_CONST_W;
`ifdef AM_LOADER_PARITY_EN
    // Trailing even-parity bit over the payload.
    localparam int FRAME_LEN      = FRAME_DATA_LEN + 1;
`else
    localparam int FRAME_LEN      = FRAME_DATA_LEN;
`endif
    localparam int BIT_CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } state_t;

    // A frame address is usable only when its top bit is clear and it
    // indexes an implemented constant.
    function automatic logic addr_in_range(input logic [FRAME_ADDR_W-1:0] addr,
                                           input int num_const);
        return !addr[FRAME_ADDR_W-1] && (int'(addr[FRAME_ADDR_W-2:0]) < num_const);
    endfunction

endpackage

// File: rtl/am_const_bank.sv
// Shadow/active constant banks with atomic commit copy and registered read port.
// Latency: shadow write 1 edge; commit copy 1 edge (ack with it); Dout 1 cycle after Sel/active change.
// Backpressure: none; writes and commits are always accepted.
// Ports: clk/rst_n (async active-low), wr_en/wr_addr/wr_data shadow write,
//        commit copies shadow->active, sel/dout read port, commit_ack pulse.
module am_const_bank
    import am_const_pkg::*;
#(
    parameter int NUM_CONST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [AM_CONST_W-1:0] wr_data,
    input  logic                  commit,
    input  logic [2:0]            sel,
    output logic [AM_CONST_W-1:0] dout,
    output logic                  commit_ack
);

    logic [AM_CONST_W-1:0] shadow [NUM_CONST];
    logic [AM_CONST_W-1:0] active [NUM_CONST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONST; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CONST; i++) begin
                if (wr_addr == 3'(i)) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

    // The whole bank moves in one edge, so the value path never sees a
    // mix of old and new constants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONST; i++) begin
                active[i] <= '0;
            end
            commit_ack <= 1'b0;
        end else begin
            commit_ack <= commit;
            if (commit) begin
                for (int i = 0; i < NUM_CONST; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Unimplemented indices read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= '0;
            for (int i = 0; i < NUM_CONST; i++) begin
                if (sel == 3'(i)) begin
                    dout <= active[i];
                end
            end
        end
    end

endmodule

// File: rtl/am_constants_loader.sv
// Serial loader of AM constants into a shadow bank, committed atomically to an active bank.
// Latency: Word_Done/Frame_Err 1 cycle after WRITE; Commit_Ack 1 cycle after Commit (2 if it hits WRITE).
// Backpressure: none; serial bits are taken whenever Ser_En is high in SHIFT.
// Ports: Clock, Reset_n (async active-low, release synchronised), Frame_Start/Ser_En/Ser_Din serial
//        frame input, Commit bank copy request, Sel/Dout read port, Word_Done/Commit_Ack/Frame_Err pulses.
// Option: AM_LOADER_PARITY_EN adds a trailing even-parity bit to each frame.
module am_constants_loader
    import am_const_pkg::*;
#(
    parameter int NUM_CONST = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Frame_Start,
    input  logic                  Ser_En,
    input  logic                  Ser_Din,
    input  logic                  Commit,
    input  logic [2:0]            Sel,
    output logic [AM_CONST_W-1:0] Dout,
    output logic                  Word_Done,
    output logic                  Commit_Ack,
    output logic                  Frame_Err
);

    // Reset asserts immediately but releases two edges later, so every
    // flop leaves reset on the same clean edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   sr_q, sr_d;
    logic                   pending_q, pending_d;
    logic                   word_done_q, word_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   wr_en;
    logic                   frame_ok;
    logic                   commit_go;
    logic [FRAME_ADDR_W-1:0] frame_addr;
    logic [AM_CONST_W-1:0]   frame_data;

    assign frame_addr = sr_q[FRAME_LEN-1 -: FRAME_ADDR_W];
    assign frame_data = sr_q[FRAME_LEN-1-FRAME_ADDR_W -: AM_CONST_W];

`ifdef AM_LOADER_PARITY_EN
    // Even parity: the XOR of all bits including the parity bit must be 0.
    assign frame_ok = addr_in_range(frame_addr, NUM_CONST) && !(^sr_q);
`else
    assign frame_ok = addr_in_range(frame_addr, NUM_CONST);
`endif

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            pending_q   <= 1'b0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            pending_q   <= pending_d;
            word_done_q <= word_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        wr_en       = 1'b0;
        word_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (Frame_Start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (Frame_Start) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                end else if (Ser_En) begin
                    sr_d = {sr_q[FRAME_LEN-2:0], Ser_Din};
                    // Counter is cleared on the last bit, so it never reaches FRAME_LEN.
                    if (cnt_q == BIT_CNT_W'(FRAME_LEN - 1)) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (Frame_Start) begin
                    // A new frame overrides the one waiting to be written.
                    frame_err_d = 1'b1;
                    state_d     = SHIFT;
                    cnt_d       = '0;
                end else begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        wr_en       = 1'b1;
                        word_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A commit landing on the write edge would copy the stale shadow word,
    // so it is held for one cycle.
    assign pending_d = Commit && (state_q == WRITE);
    assign commit_go = (Commit && (state_q != WRITE)) || pending_q;

    assign Word_Done = word_done_q;
    assign Frame_Err = frame_err_q;

    am_const_bank #(
        .NUM_CONST (NUM_CONST)
    ) u_bank (
        .clk        (Clock),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (frame_addr[FRAME_ADDR_W-2:0]),
        .wr_data    (frame_data),
        .commit     (commit_go),
        .sel        (Sel),
        .dout       (Dout),
        .commit_ack (Commit_Ack)
    );

endmodule

// File: tb/tb_am_constants_loader.sv
// Directed bench for am_constants_loader: frames, commits, aborts, bad addresses, reset.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_am_constants_loader;

    logic        Clock;
    logic        Reset_n;
    logic        Frame_Start;
    logic        Ser_En;
    logic        Ser_Din;
    logic        Commit;
    logic [2:0]  Sel;
    logic [15:0] Dout;
    logic        Word_Done;
    logic        Commit_Ack;
    logic        Frame_Err;

    int n_checks = 0;
    int n_fail   = 0;
    int wd_cnt   = 0;
    int err_cnt  = 0;
    int ack_cnt  = 0;
    int wd0, err0, ack0;

    am_constants_loader #(
        .NUM_CONST (8)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Frame_Start (Frame_Start),
        .Ser_En      (Ser_En),
        .Ser_Din     (Ser_Din),
        .Commit      (Commit),
        .Sel         (Sel),
        .Dout        (Dout),
        .Word_Done   (Word_Done),
        .Commit_Ack  (Commit_Ack),
        .Frame_Err   (Frame_Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (Word_Done)  wd_cnt++;
        if (Frame_Err)  err_cnt++;
        if (Commit_Ack) ack_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        Ser_En  = 1'b1;
        Ser_Din = b;
        cycle();
        Ser_En  = 1'b0;
        Ser_Din = 1'b0;
    endtask

    // Returns one step after the last bit edge, i.e. with the DUT in WRITE.
    task automatic send_frame(input logic [3:0] addr, input logic [15:0] data, input logic flip_par);
        logic [19:0] f;
        f = {addr, data};
        Frame_Start = 1'b1;
        cycle();
        Frame_Start = 1'b0;
        for (int i = 19; i >= 0; i--) begin
            send_bit(f[i]);
        end
`ifdef AM_LOADER_PARITY_EN
        send_bit((^f) ^ flip_par);
`else
        if (flip_par) begin
            // Parity is not part of the frame in this build.
        end
`endif
    endtask

    task automatic start_partial(input int nbits);
        Frame_Start = 1'b1;
        cycle();
        Frame_Start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(i[0]);
        end
    endtask

    task automatic do_commit();
        Commit = 1'b1;
        cycle();
        Commit = 1'b0;
        cycle();
    endtask

    task automatic read_sel(input logic [2:0] s, input string tag, input logic [15:0] exp);
        Sel = s;
        cycle();
        check_val(tag, {16'h0, Dout}, {16'h0, exp});
    endtask

    initial begin
        Reset_n     = 1'b0;
        Frame_Start = 1'b0;
        Ser_En      = 1'b0;
        Ser_Din     = 1'b0;
        Commit      = 1'b0;
        Sel         = 3'd0;
        repeat (3) cycle();
        check_val("rst_dout",      {16'h0, Dout}, 32'h0);
        check_val("rst_word_done", {31'h0, Word_Done}, 32'h0);
        check_val("rst_commit_ack",{31'h0, Commit_Ack}, 32'h0);
        check_val("rst_frame_err", {31'h0, Frame_Err}, 32'h0);
        Reset_n = 1'b1;
        repeat (3) cycle();

`ifdef AM_LOADER_PARITY_EN
        // Bad parity on a fresh bank: word dropped, error flagged.
        send_frame(4'd0, 16'h0001, 1'b1);
        cycle();
        check_val("par_err",       {31'h0, Frame_Err}, 32'h1);
        check_val("par_no_wd",     {31'h0, Word_Done}, 32'h0);
        do_commit();
        read_sel(3'd0, "par_shadow0", 16'h0000);
`endif

        // Basic frame then commit.
        wd0 = wd_cnt; ack0 = ack_cnt;
        Sel = 3'd2;
        send_frame(4'd2, 16'h1234, 1'b0);
        cycle();
        check_val("f1_word_done", {31'h0, Word_Done}, 32'h1);
        Commit = 1'b1;
        cycle();
        Commit = 1'b0;
        check_val("f1_ack",        {31'h0, Commit_Ack}, 32'h1);
        check_val("f1_dout_early", {16'h0, Dout}, 32'h0);
        cycle();
        check_val("f1_ack_drop",   {31'h0, Commit_Ack}, 32'h0);
        check_val("f1_dout",       {16'h0, Dout}, 32'h1234);
        cycle();
        check_val("f1_wd_pulses",  wd_cnt - wd0, 1);
        check_val("f1_ack_pulses", ack_cnt - ack0, 1);

        // Shadow write stays invisible until commit.
        send_frame(4'd1, 16'hAAAA, 1'b0);
        cycle();
        Sel = 3'd1;
        repeat (2) cycle();
        check_val("f2_precommit", {16'h0, Dout}, 32'h0);
        do_commit();
        check_val("f2_postcommit", {16'h0, Dout}, 32'hAAAA);

        // Frame_Start mid-frame aborts; only the restarted frame lands.
        wd0 = wd_cnt; err0 = err_cnt;
        start_partial(9);
        send_frame(4'd3, 16'h0F0F, 1'b0);
        repeat (2) cycle();
        check_val("f3_err_pulses", err_cnt - err0, 1);
        check_val("f3_wd_pulses",  wd_cnt - wd0, 1);
        do_commit();
        read_sel(3'd3, "f3_addr3", 16'h0F0F);
        read_sel(3'd5, "f3_addr5", 16'h0000);

        // Commit colliding with WRITE is deferred one cycle.
        Sel = 3'd0;
        send_frame(4'd0, 16'hBEEF, 1'b0);
        Commit = 1'b1;
        cycle();
        Commit = 1'b0;
        check_val("f4_ack_deferred", {31'h0, Commit_Ack}, 32'h0);
        cycle();
        check_val("f4_ack",       {31'h0, Commit_Ack}, 32'h1);
        cycle();
        check_val("f4_dout",      {16'h0, Dout}, 32'hBEEF);

        // addr 0x9 is out of range: rejected, banks untouched.
        wd0 = wd_cnt; err0 = err_cnt;
        send_frame(4'h9, 16'h5555, 1'b0);
        cycle();
        check_val("f5_err",     {31'h0, Frame_Err}, 32'h1);
        check_val("f5_no_wd",   {31'h0, Word_Done}, 32'h0);
        do_commit();
        check_val("f5_wd_pulses",  wd_cnt - wd0, 0);
        check_val("f5_err_pulses", err_cnt - err0, 1);
        read_sel(3'd0, "f5_bank0", 16'hBEEF);
        read_sel(3'd1, "f5_bank1", 16'hAAAA);
        read_sel(3'd2, "f5_bank2", 16'h1234);
        read_sel(3'd3, "f5_bank3", 16'h0F0F);
        read_sel(3'd4, "f5_bank4", 16'h0000);

        // Reset mid-frame: no error, everything cleared.
        err0 = err_cnt; wd0 = wd_cnt;
        start_partial(7);
        Reset_n = 1'b0;
        repeat (2) cycle();
        check_val("rst2_dout", {16'h0, Dout}, 32'h0);
        Reset_n = 1'b1;
        repeat (3) cycle();
        check_val("rst2_no_err", err_cnt - err0, 0);
        read_sel(3'd2, "rst2_active_clr", 16'h0000);

        // Ser_En in IDLE is ignored.
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1);
        end
        repeat (2) cycle();
        check_val("idle_no_wd",  wd_cnt - wd0, 0);
        check_val("idle_no_err", err_cnt - err0, 0);

        // Still functional after reset.
        send_frame(4'd4, 16'hC3C3, 1'b0);
        cycle();
        check_val("post_rst_wd", {31'h0, Word_Done}, 32'h1);
        do_commit();
        read_sel(3'd4, "post_rst_dout", 16'hC3C3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
